trakball_decoder: RTL and testbench

TRAKBALL_DECODER -- requirements
Module: trakball_decoder

---
 rtl/trakball_decoder_pkg.sv | 24 ++
 rtl/trak_axis.sv | 59 +++++
 rtl/trakball_decoder.sv | 77 +++++++
 tb/tb_trakball_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/trakball_decoder_pkg.sv
// trakball_decoder_pkg: shared constants, axis encoding and read-word packing for the trackball decoder
package trakball_decoder_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic {
        AXIS_X = 1'b0,
        AXIS_Y = 1'b1
    } axis_e;

    localparam int XDIR_HI = 7;
    localparam int XDIR_LO = 6;
    localparam int XCLK_HI = 5;
    localparam int XCLK_LO = 4;
    localparam int YDIR_HI = 3;
    localparam int YDIR_LO = 2;
    localparam int YCLK_HI = 1;
    localparam int YCLK_LO = 0;

    function automatic logic [7:0] rd_word(input logic dir, input logic moved, input logic [3:0] cnt);
        return {dir, moved, 2'b00, cnt};
    endfunction

endpackage

// File: rtl/trak_axis.sv
// trak_axis: qualifies one axis's doubled lines, detects clock edges and tracks count, dir and moved
module trak_axis #(
    parameter int CNT_W = 4
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [1:0]       dir_pair_i,
    input  logic [1:0]       clk_pair_i,
    input  logic             flip_i,
    input  logic             rd_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             dir_o,
    output logic             moved_o
);

    logic             dir_qual_q, dir_qual_d;
    logic             clk_qual_q, clk_qual_d;
    logic             clk_prev_q;
    logic             dir_q, dir_d;
    logic             moved_q, moved_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step, up;

    assign step = clk_qual_q ^ clk_prev_q;
    assign up   = dir_qual_q ^ flip_i;

    // A line only updates when both copies agree; otherwise the old value holds.
    always_comb begin
        dir_qual_d = (dir_pair_i[1] == dir_pair_i[0]) ? dir_pair_i[0] : dir_qual_q;
        clk_qual_d = (clk_pair_i[1] == clk_pair_i[0]) ? clk_pair_i[0] : clk_qual_q;
        cnt_d      = clr_i ? '0 : step ? (up ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1)) : cnt_q;
        dir_d      = (step && !clr_i) ? up : dir_q;
        moved_d    = clr_i ? 1'b0 : step ? 1'b1 : rd_i ? 1'b0 : moved_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dir_qual_q <= 1'b0;
            clk_qual_q <= 1'b0;
            clk_prev_q <= 1'b0;
            dir_q      <= 1'b0;
            moved_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            dir_qual_q <= dir_qual_d;
            clk_qual_q <= clk_qual_d;
            clk_prev_q <= clk_qual_q;
            dir_q      <= dir_d;
            moved_q    <= moved_d;
            cnt_q      <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign dir_o   = dir_q;
    assign moved_o = moved_q;

endmodule

// File: rtl/trakball_decoder.sv
// trakball_decoder: synchronises trackball lines, decodes X/Y motion and serves registered axis reads
module trakball_decoder
    import trakball_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] trakball_i,
    input  logic       flip_i,
    input  logic       sel_i,
    input  logic       rd_i,
    input  logic       clr_i,
    output logic [7:0] data_o,
    output logic       rd_valid_o
);

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0]                  s;
    logic [CNT_W-1:0]            x_cnt, y_cnt;
    logic                        x_dir, y_dir, x_moved, y_moved;
    logic                        rd_x, rd_y;
    logic [7:0]                  data_q, data_d;
    logic                        rd_valid_q;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rd_x = rd_i && (axis_e'(sel_i) == AXIS_X);
    assign rd_y = rd_i && (axis_e'(sel_i) == AXIS_Y);

    trak_axis #(.CNT_W(CNT_W)) u_x (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dir_pair_i (s[XDIR_HI:XDIR_LO]),
        .clk_pair_i (s[XCLK_HI:XCLK_LO]),
        .flip_i     (flip_i),
        .rd_i       (rd_x),
        .clr_i      (clr_i),
        .count_o    (x_cnt),
        .dir_o      (x_dir),
        .moved_o    (x_moved)
    );

    trak_axis #(.CNT_W(CNT_W)) u_y (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dir_pair_i (s[YDIR_HI:YDIR_LO]),
        .clk_pair_i (s[YCLK_HI:YCLK_LO]),
        .flip_i     (flip_i),
        .rd_i       (rd_y),
        .clr_i      (clr_i),
        .count_o    (y_cnt),
        .dir_o      (y_dir),
        .moved_o    (y_moved)
    );

    // Read data comes from the registered axis state, i.e. before any same-cycle step or clear.
    always_comb begin
        data_d = rd_y ? rd_word(y_dir, y_moved, 4'(y_cnt)) : rd_x ? rd_word(x_dir, x_moved, 4'(x_cnt)) : data_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], trakball_i};
            data_q     <= data_d;
            rd_valid_q <= rd_i;
        end
    end

    assign data_o     = data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_trakball_decoder.sv
// tb_trakball_decoder: directed scoreboard bench for trakball_decoder with an independent axis model
module tb_trakball_decoder;

    localparam int N = 2;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] trakball_i = '0;
    logic       flip_i = 1'b0;
    logic       sel_i = 1'b0;
    logic       rd_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [7:0] data_o;
    logic       rd_valid_o;

    int n_vec = 0;
    int n_err = 0;

    logic       xd = 0, xc = 0, yd = 0, yc = 0;
    logic [3:0] m_cnt [2];
    logic       m_dir [2];
    logic       m_mov [2];
    logic [7:0] exp_q [$];
    logic [7:0] held;

    trakball_decoder #(.SYNC_STAGES(N), .CNT_W(4)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .trakball_i (trakball_i),
        .flip_i     (flip_i),
        .sel_i      (sel_i),
        .rd_i       (rd_i),
        .clr_i      (clr_i),
        .data_o     (data_o),
        .rd_valid_o (rd_valid_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            m_cnt[a] = '0;
            m_dir[a] = 1'b0;
            m_mov[a] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic apply_lines();
        trakball_i = {xd, xd, xc, xc, yd, yd, yc, yc};
    endtask

    task automatic model_step(input int a, input logic d);
        logic up;
        up = d ^ flip_i;
        m_cnt[a] = up ? m_cnt[a] + 4'd1 : m_cnt[a] - 4'd1;
        m_dir[a] = up;
        m_mov[a] = 1'b1;
    endtask

    task automatic drive_step(input int a, input logic d);
        if (a == 0) begin
            xd = d;
            xc = ~xc;
        end else begin
            yd = d;
            yc = ~yc;
        end
        apply_lines();
    endtask

    task automatic step_axis(input int a, input logic d);
        drive_step(a, d);
        model_step(a, d);
        repeat (N + 3) tick();
    endtask

    task automatic do_read(input int a, input string tag);
        int waited;
        exp_q.push_back({m_dir[a], m_mov[a], 2'b00, m_cnt[a]});
        m_mov[a] = 1'b0;
        sel_i = a[0];
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
        waited = 0;
        while (!rd_valid_o && waited < 4) begin
            tick();
            waited++;
        end
        chk({tag, "_valid"}, {7'd0, rd_valid_o}, 8'd1);
        if (exp_q.size() > 0) chk(tag, data_o, exp_q.pop_front());
        tick();
        chk({tag, "_valid_drop"}, {7'd0, rd_valid_o}, 8'd0);
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        for (int a = 0; a < 2; a++) begin
            m_cnt[a] = '0;
            m_mov[a] = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        chk("reset_data", data_o, 8'h00);
        chk("reset_valid", {7'd0, rd_valid_o}, 8'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Five X toggles upward.
        for (int i = 0; i < 5; i++) step_axis(0, 1'b1);
        do_read(0, "x_five_steps");
        chk("x_five_const", held, held);
        held = data_o;
        repeat (3) tick();
        chk("data_hold", data_o, 8'hC5);

        // Y decrement from 0 under flip wraps to 15.
        do_clr();
        flip_i = 1'b1;
        step_axis(1, 1'b1);
        do_read(1, "y_flip_wrap");
        chk("y_flip_const", data_o, 8'h4F);
        do_read(1, "y_second_read");
        flip_i = 1'b0;

        // Disagreeing xclk copies must never step.
        do_read(0, "x_before_glitch");
        trakball_i[5] = ~xc;
        repeat (5) tick();
        trakball_i[5] = xc;
        trakball_i[4] = ~xc;
        repeat (5) tick();
        apply_lines();
        repeat (N + 3) tick();
        do_read(0, "x_after_glitch");

        // Read coinciding with a step from count 3.
        do_clr();
        for (int i = 0; i < 3; i++) step_axis(0, 1'b1);
        do_read(0, "x_count3");
        drive_step(0, 1'b1);
        repeat (N + 1) tick();
        do_read(0, "x_coincident");
        model_step(0, 1'b1);
        repeat (2) tick();
        do_read(0, "x_after_coincident");

        // X and Y step together, then wrap 15 -> 0 upward on Y.
        do_clr();
        drive_step(0, 1'b0);
        drive_step(1, 1'b0);
        model_step(0, 1'b0);
        model_step(1, 1'b0);
        repeat (N + 3) tick();
        do_read(0, "xy_same_x");
        do_read(1, "xy_same_y");
        step_axis(1, 1'b1);
        do_read(1, "y_wrap_up");

        // Clear coinciding with X and Y steps wins; read with clear returns pre-clear values.
        for (int i = 0; i < 2; i++) step_axis(1, 1'b1);
        drive_step(0, 1'b1);
        drive_step(1, 1'b1);
        repeat (N + 1) tick();
        exp_q.push_back({m_dir[1], m_mov[1], 2'b00, m_cnt[1]});
        sel_i = 1'b1;
        rd_i = 1'b1;
        clr_i = 1'b1;
        tick();
        rd_i = 1'b0;
        clr_i = 1'b0;
        for (int a = 0; a < 2; a++) begin
            m_cnt[a] = '0;
            m_mov[a] = 1'b0;
        end
        chk("rd_clr_valid", {7'd0, rd_valid_o}, 8'd1);
        if (exp_q.size() > 0) chk("rd_clr_data", data_o, exp_q.pop_front());
        repeat (N + 2) tick();
        do_read(0, "clr_step_x");
        do_read(1, "clr_step_y");

        // Asynchronous reset mid-stream.
        step_axis(0, 1'b1);
        do_read(0, "x_pre_reset");
        xd = 0; xc = 0; yd = 0; yc = 0;
        apply_lines();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_data", data_o, 8'h00);
        chk("async_reset_valid", {7'd0, rd_valid_o}, 8'd0);
        model_reset();
        tick();
        reset_n = 1'b1;
        repeat (N + 3) tick();
        do_read(0, "x_post_reset");
        do_read(1, "y_post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
